// File: rtl/char_pkg.sv
// Shared definitions for the player character life cycle: life states,
// game mode and class codes, and default per-class maximum HP.
package char_pkg;

    typedef enum logic [1:0] {
        LS_IDLE   = 2'd0,
        LS_ALIVE  = 2'd1,
        LS_INVULN = 2'd2,
        LS_DEAD   = 2'd3
    } life_state_e;

    localparam logic [1:0] GAME_MENU = 2'd0;
    localparam logic [1:0] GAME_PLAY = 2'd1;

    localparam logic [1:0] CLASS_MELEE  = 2'd0;
    localparam logic [1:0] CLASS_ARCHER = 2'd1;

    localparam logic [3:0] DEF_MAX_HP_MELEE  = 4'd10;
    localparam logic [3:0] DEF_MAX_HP_ARCHER = 4'd6;

endpackage

// File: rtl/char_frame_timer.sv
// Frame-tick driven invulnerability down-counter with sprite blink divider.
module char_frame_timer #(
    parameter int INVULN_FRAMES = 60,
    parameter int BLINK_FRAMES  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clear,
    input  logic freeze,
    input  logic frame_tick,
    output logic done,
    output logic blink_visible
);

    logic [7:0] win_cnt_r;
    logic [3:0] blink_cnt_r;
    logic       vis_r;
    logic       tick_s;

    assign tick_s        = frame_tick && !freeze && (win_cnt_r != 8'd0);
    assign done          = tick_s && (win_cnt_r == 8'd1);
    assign blink_visible = vis_r;

    // Window countdown; the final tick forces the sprite back to visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt_r   <= 8'd0;
            blink_cnt_r <= 4'd0;
            vis_r       <= 1'b1;
        end else if (clear) begin
            win_cnt_r   <= 8'd0;
            blink_cnt_r <= 4'd0;
            vis_r       <= 1'b1;
        end else if (load) begin
            win_cnt_r   <= 8'(INVULN_FRAMES);
            blink_cnt_r <= 4'(BLINK_FRAMES);
            vis_r       <= 1'b1;
        end else if (tick_s) begin
            win_cnt_r <= win_cnt_r - 8'd1;
            if (win_cnt_r == 8'd1) begin
                blink_cnt_r <= 4'd0;
                vis_r       <= 1'b1;
            end else if (blink_cnt_r == 4'd1) begin
                blink_cnt_r <= 4'(BLINK_FRAMES);
                vis_r       <= ~vis_r;
            end else begin
                blink_cnt_r <= blink_cnt_r - 4'd1;
            end
        end
    end

endmodule

// File: rtl/char_life_ctrl.sv
// Player character life-cycle sequencer: spawn, damage, invulnerability
// window with blink, heal, death and respawn.
module char_life_ctrl
    import char_pkg::*;
#(
    parameter logic [3:0] MAX_HP_MELEE  = DEF_MAX_HP_MELEE,
    parameter logic [3:0] MAX_HP_ARCHER = DEF_MAX_HP_ARCHER,
    parameter int         INVULN_FRAMES = 60,
    parameter int         BLINK_FRAMES  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [1:0] game_active,
    input  logic       game_start,
    input  logic [1:0] char_class,
    input  logic       hit_valid,
    input  logic [3:0] hit_dmg,
    input  logic       heal_valid,
    input  logic [3:0] heal_amt,
    output logic       hit_ack,
    output logic [3:0] char_hp,
    output logic       alive,
    output logic       invuln,
    output logic       blink_visible,
    output logic       death_pulse
);

    localparam logic [1:0] ST_IDLE   = 2'(LS_IDLE);
    localparam logic [1:0] ST_ALIVE  = 2'(LS_ALIVE);
    localparam logic [1:0] ST_INVULN = 2'(LS_INVULN);
    localparam logic [1:0] ST_DEAD   = 2'(LS_DEAD);

    logic [1:0] state_r, state_s;
    logic [3:0] hp_r, hp_s;
    logic [3:0] max_hp_r, max_hp_s;
    logic       alive_r, alive_s;
    logic       invuln_r, invuln_s;
    logic       ack_r, ack_s;
    logic       death_r, death_s;
    logic       load_s, clear_s, freeze_s, done_s;
    logic       hit_take_s;
    logic [3:0] spawn_max_s;
    logic [4:0] heal_sum_s;
    logic [3:0] healed_hp_s;

    // A hit acked last cycle is not re-consumed, so acks never run back to back.
    assign hit_take_s  = hit_valid && !ack_r;
    assign spawn_max_s = (char_class == CLASS_MELEE) ? MAX_HP_MELEE : MAX_HP_ARCHER;
    assign heal_sum_s  = {1'b0, hp_r} + {1'b0, heal_amt};
    assign healed_hp_s = (heal_sum_s > {1'b0, max_hp_r}) ? max_hp_r : heal_sum_s[3:0];
    assign freeze_s    = (game_active != GAME_PLAY);

    char_frame_timer #(
        .INVULN_FRAMES (INVULN_FRAMES),
        .BLINK_FRAMES  (BLINK_FRAMES)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .load          (load_s),
        .clear         (clear_s),
        .freeze        (freeze_s),
        .frame_tick    (frame_tick),
        .done          (done_s),
        .blink_visible (blink_visible)
    );

    // Next-state and output decode; spawn beats menu, menu beats play logic.
    always_comb begin
        state_s  = state_r;
        hp_s     = hp_r;
        max_hp_s = max_hp_r;
        alive_s  = alive_r;
        invuln_s = invuln_r;
        ack_s    = 1'b0;
        death_s  = 1'b0;
        load_s   = 1'b0;
        clear_s  = 1'b0;
        if (game_start) begin
            state_s  = ST_ALIVE;
            hp_s     = spawn_max_s;
            max_hp_s = spawn_max_s;
            alive_s  = 1'b1;
            invuln_s = 1'b0;
            ack_s    = hit_take_s;
            clear_s  = 1'b1;
        end else if (game_active == GAME_MENU) begin
            state_s  = ST_IDLE;
            hp_s     = 4'd0;
            alive_s  = 1'b0;
            invuln_s = 1'b0;
            ack_s    = hit_take_s;
            clear_s  = 1'b1;
        end else if (game_active != GAME_PLAY) begin
            ack_s = hit_take_s;
        end else begin
            case (state_r)
                ST_ALIVE: begin
                    if (hit_take_s) begin
                        ack_s = 1'b1;
                        if (hit_dmg == 4'd0) begin
                            hp_s = hp_r;
                        end else if ({1'b0, hit_dmg} >= {1'b0, hp_r}) begin
                            state_s = ST_DEAD;
                            hp_s    = 4'd0;
                            alive_s = 1'b0;
                            death_s = 1'b1;
                        end else begin
                            state_s  = ST_INVULN;
                            hp_s     = hp_r - hit_dmg;
                            invuln_s = 1'b1;
                            load_s   = 1'b1;
                        end
                    end else if (heal_valid) begin
                        hp_s = healed_hp_s;
                    end else begin
                        hp_s = hp_r;
                    end
                end
                ST_INVULN: begin
                    if (hit_take_s) begin
                        ack_s = 1'b1;
                    end else if (heal_valid) begin
                        hp_s = healed_hp_s;
                    end else begin
                        hp_s = hp_r;
                    end
                    if (done_s) begin
                        state_s  = ST_ALIVE;
                        invuln_s = 1'b0;
                    end else begin
                        state_s = ST_INVULN;
                    end
                end
                ST_IDLE, ST_DEAD: begin
                    ack_s = hit_take_s;
                end
                default: begin
                    state_s  = ST_IDLE;
                    hp_s     = 4'd0;
                    alive_s  = 1'b0;
                    invuln_s = 1'b0;
                    clear_s  = 1'b1;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            hp_r     <= 4'd0;
            max_hp_r <= 4'd0;
            alive_r  <= 1'b0;
            invuln_r <= 1'b0;
            ack_r    <= 1'b0;
            death_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            hp_r     <= hp_s;
            max_hp_r <= max_hp_s;
            alive_r  <= alive_s;
            invuln_r <= invuln_s;
            ack_r    <= ack_s;
            death_r  <= death_s;
        end
    end

    assign hit_ack     = ack_r;
    assign char_hp     = hp_r;
    assign alive       = alive_r;
    assign invuln      = invuln_r;
    assign death_pulse = death_r;

endmodule

// File: tb/tb_char_life_ctrl.sv
// Directed bench for char_life_ctrl: a life-cycle model checked every cycle
// plus literal expectations at the key points of each scenario.
module tb_char_life_ctrl;
    import char_pkg::*;

    localparam int INV = 8;
    localparam int BLK = 2;
    localparam int S_IDLE = 0, S_ALIVE = 1, S_INV = 2, S_DEAD = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic [1:0] game_active = GAME_PLAY;
    logic       game_start = 1'b0;
    logic [1:0] char_class = CLASS_MELEE;
    logic       hit_valid = 1'b0;
    logic [3:0] hit_dmg = 4'd0;
    logic       heal_valid = 1'b0;
    logic [3:0] heal_amt = 4'd0;
    logic       hit_ack, alive, invuln, blink_visible, death_pulse;
    logic [3:0] char_hp;

    int n_cmp = 0;
    int n_err = 0;

    char_life_ctrl #(.INVULN_FRAMES(INV), .BLINK_FRAMES(BLK)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_active(game_active),
        .game_start(game_start), .char_class(char_class), .hit_valid(hit_valid),
        .hit_dmg(hit_dmg), .heal_valid(heal_valid), .heal_amt(heal_amt),
        .hit_ack(hit_ack), .char_hp(char_hp), .alive(alive), .invuln(invuln),
        .blink_visible(blink_visible), .death_pulse(death_pulse)
    );

    always #5 clk = ~clk;

    // Model: life state, hp, class max, frames left in window, last ack/death.
    int m_state, m_hp, m_max, m_win;
    bit m_ack, m_death;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int heal_to(input int hp, input int amt, input int mx);
        return (hp + amt > mx) ? mx : hp + amt;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= S_IDLE; m_hp <= 0; m_max <= 0; m_win <= 0;
            m_ack <= 1'b0; m_death <= 1'b0;
        end else begin
            int st, hp, mx, win;
            bit ack, dth, take;
            st = m_state; hp = m_hp; mx = m_max; win = m_win;
            ack = 1'b0; dth = 1'b0;
            take = hit_valid && !m_ack;
            if (game_start) begin
                mx = (char_class == CLASS_MELEE) ? 10 : 6;
                hp = mx; st = S_ALIVE; win = 0; ack = take;
            end else if (game_active == GAME_MENU) begin
                st = S_IDLE; hp = 0; win = 0; ack = take;
            end else if (game_active != GAME_PLAY) begin
                ack = take;
            end else if (st == S_ALIVE) begin
                if (take) begin
                    ack = 1'b1;
                    if (hit_dmg != 0) begin
                        if (int'(hit_dmg) >= hp) begin
                            hp = 0; st = S_DEAD; dth = 1'b1;
                        end else begin
                            hp = hp - int'(hit_dmg); st = S_INV; win = INV;
                        end
                    end
                end else if (heal_valid) begin
                    hp = heal_to(hp, int'(heal_amt), mx);
                end
            end else if (st == S_INV) begin
                if (take) ack = 1'b1;
                else if (heal_valid) hp = heal_to(hp, int'(heal_amt), mx);
                if (frame_tick) begin
                    win = win - 1;
                    if (win == 0) st = S_ALIVE;
                end
            end else begin
                ack = take;
            end
            m_state <= st; m_hp <= hp; m_max <= mx; m_win <= win;
            m_ack <= ack; m_death <= dth;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("char_hp", int'(char_hp), m_hp);
            check("alive", int'(alive), (m_state == S_ALIVE || m_state == S_INV) ? 1 : 0);
            check("invuln", int'(invuln), (m_state == S_INV) ? 1 : 0);
            check("blink_visible", int'(blink_visible),
                  (m_state == S_INV) ? ((((INV - m_win) / BLK) % 2 == 0) ? 1 : 0) : 1);
            check("hit_ack", int'(hit_ack), int'(m_ack));
            check("death_pulse", int'(death_pulse), int'(m_death));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1; cyc();
            frame_tick = 1'b0; cyc();
        end
    endtask

    task automatic spawn(input logic [1:0] cls);
        char_class = cls; game_start = 1'b1; cyc();
        game_start = 1'b0;
    endtask

    task automatic hit(input logic [3:0] d);
        hit_valid = 1'b1; hit_dmg = d; cyc();
        hit_valid = 1'b0;
    endtask

    initial begin
        int vis_tab [7];
        vis_tab = '{1, 0, 0, 1, 1, 0, 0};
        cyc(2);
        rst = 1'b0;
        cyc();
        check("rst_hp", int'(char_hp), 0);
        check("rst_alive", int'(alive), 0);
        check("rst_vis", int'(blink_visible), 1);

        spawn(CLASS_MELEE);
        check("melee_hp", int'(char_hp), 10);
        check("melee_alive", int'(alive), 1);
        check("melee_inv", int'(invuln), 0);

        spawn(CLASS_ARCHER);
        hit_valid = 1'b1; hit_dmg = 4'd2; cyc();
        check("hit_ack", int'(hit_ack), 1);
        check("hit_hp", int'(char_hp), 4);
        check("hit_inv", int'(invuln), 1);
        cyc();
        check("ack_gap", int'(hit_ack), 0);
        cyc();
        check("inv_ack", int'(hit_ack), 1);
        check("inv_hp", int'(char_hp), 4);
        hit_valid = 1'b0; cyc();

        for (int k = 1; k <= 7; k++) begin
            frame_tick = 1'b1; cyc();
            check("blink_tick", int'(blink_visible), vis_tab[k-1]);
            frame_tick = 1'b0; cyc();
        end
        frame_tick = 1'b1; cyc();
        frame_tick = 1'b0;
        check("win_end_inv", int'(invuln), 0);
        check("win_end_vis", int'(blink_visible), 1);
        cyc();

        hit(4'd7);
        check("death_hp", int'(char_hp), 0);
        check("death_alive", int'(alive), 0);
        check("death_pulse", int'(death_pulse), 1);
        cyc();
        check("death_once", int'(death_pulse), 0);
        hit(4'd3);
        spawn(CLASS_ARCHER);
        check("respawn_hp", int'(char_hp), 6);
        check("respawn_alive", int'(alive), 1);

        spawn(CLASS_MELEE);
        hit(4'd1);
        check("melee_hit_hp", int'(char_hp), 9);
        ticks(INV);
        heal_valid = 1'b1; heal_amt = 4'd5; cyc();
        heal_valid = 1'b0;
        check("heal_clamp", int'(char_hp), 10);
        hit_valid = 1'b1; hit_dmg = 4'd3; heal_valid = 1'b1; heal_amt = 4'd3; cyc();
        hit_valid = 1'b0; heal_valid = 1'b0;
        check("hit_beats_heal", int'(char_hp), 7);
        cyc();

        game_active = 2'd2;
        ticks(3);
        hit(4'd1);
        heal_valid = 1'b1; heal_amt = 4'd1; cyc();
        heal_valid = 1'b0;
        check("pause_inv", int'(invuln), 1);
        check("pause_hp", int'(char_hp), 7);
        game_active = GAME_PLAY;
        ticks(INV);
        check("pause_resume", int'(invuln), 0);

        hit(4'd2);
        ticks(1);
        game_active = GAME_MENU; cyc();
        check("menu_hp", int'(char_hp), 0);
        check("menu_alive", int'(alive), 0);
        check("menu_inv", int'(invuln), 0);
        check("menu_vis", int'(blink_visible), 1);
        game_active = GAME_PLAY; cyc();

        spawn(CLASS_MELEE);
        hit(4'd4);
        ticks(2);
        check("pre_rst_vis", int'(blink_visible), 0);
        #2 rst = 1'b1;
        #1;
        check("arst_hp", int'(char_hp), 0);
        check("arst_alive", int'(alive), 0);
        check("arst_inv", int'(invuln), 0);
        check("arst_vis", int'(blink_visible), 1);
        cyc();
        rst = 1'b0;
        hit_valid = 1'b1; hit_dmg = 4'd5;
        cyc(4);
        hit_valid = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/char_life_ctrl.md
Name: char_life_ctrl

Overview:
- Sequences the player character's life cycle: spawn at class-dependent max HP, damage intake, post-hit invulnerability window with sprite blink, death, and respawn on game start.
- Sits between the boss/projectile collision logic and the character top level.
- Its char_hp feeds the hearts display, and its alive and blink_visible outputs gate the character sprite draw.
- Time-based behaviour advances only on frame_tick.

Parameters:
- MAX_HP_MELEE, 10, HP loaded at spawn when char_class = CLASS_MELEE.
- MAX_HP_ARCHER, 6, HP loaded at spawn for any other char_class.
- INVULN_FRAMES, 60, length of the invulnerability window in frame_ticks (1..255).
- BLINK_FRAMES, 4, frame_ticks per blink half-period during invulnerability (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- game_active  in  2  game mode; GAME_MENU=0, GAME_PLAY=1, others = game over/paused
- game_start  in  1  one-cycle pulse; (re)spawn request
- char_class  in  2  selected class, sampled at spawn
- hit_valid  in  1  damage request, held until hit_ack
- hit_dmg  in  4  damage amount, valid with hit_valid
- heal_valid  in  1  one-cycle heal pulse
- heal_amt  in  4  heal amount
- hit_ack  out  1  one-cycle pulse: hit consumed (applied or discarded)
- char_hp  out  4  current health
- alive  out  1  character alive
- invuln  out  1  invulnerability window active
- blink_visible  out  1  sprite draw enable
- death_pulse  out  1  one-cycle pulse on transition to DEAD

Behaviour:
- Reset: all outputs registered.
  - state=IDLE, char_hp=0, alive=0, invuln=0, blink_visible=1, hit_ack=0, death_pulse=0.
  - Counters are cleared.
- State IDLE:
  - alive=0, char_hp=0.
  - game_start=1 -> load char_hp from class max, go to ALIVE.
  - hit_valid is acked and discarded.
- Spawn (game_start in any state, highest priority):
  - Next cycle: char_hp = max for char_class sampled that cycle, alive=1, invuln=0, blink_visible=1, state=ALIVE.
  - A hit or heal in the same cycle is dropped; hit_ack is still asserted.
- State ALIVE, game_active=GAME_PLAY, hit_valid=1:
  - hit_ack asserted next cycle; char_hp updated the same next cycle (1-cycle latency).
  - hit_dmg=0: ack only, no other effect.
  - hit_dmg >= char_hp: char_hp=0, alive=0, death_pulse=1 for one cycle, go to DEAD.
  - Otherwise: char_hp -= hit_dmg, invuln=1, load invuln counter=INVULN_FRAMES and blink counter=BLINK_FRAMES, go to INVULN.
  - Damage arithmetic compares in 5 bits; no wrap.
- State INVULN:
  - hit_valid is acked and discarded.
  - On each frame_tick: invuln counter decrements. The blink counter also decrements; when it hits 0 it reloads BLINK_FRAMES and blink_visible toggles.
  - A frame_tick with invuln counter=1 -> state ALIVE, invuln=0, blink_visible=1.
- Heal (ALIVE or INVULN, no game_start, no hit accepted the same cycle):
  - char_hp = min(char_hp + heal_amt, class max), computed in 5 bits.
  - Hit and heal in the same cycle: hit wins, heal is dropped.
  - The class max is the one latched at spawn.
- State DEAD: alive=0, char_hp=0; hits acked and discarded; only game_start leaves.
- game_active != GAME_PLAY:
  - Hits are acked and discarded; heals are ignored; timers freeze.
  - game_active=GAME_MENU from any state -> IDLE on the next cycle, with reset output values.
- hit_ack is never asserted in two consecutive cycles. A hit_valid still high the cycle after its ack is a new request.
- Asynchronous reset mid-window clears all state immediately.

Decomposition:
- Shared package char_pkg holds:
  - life state enum (IDLE, ALIVE, INVULN, DEAD)
  - GAME_MENU/GAME_PLAY codes
  - CLASS_MELEE/CLASS_ARCHER codes
  - default max-HP constants, used by hearts display and bench
- Sub-module char_frame_timer holds the frame_tick-driven invuln down-counter and blink divider.
  - Inputs: load, freeze, frame_tick.
  - Outputs: done, blink_visible.

Test Plan:
- Run with INVULN_FRAMES=8, BLINK_FRAMES=2.
- Reset, then game_start with char_class=CLASS_MELEE, game_active=1 -> next cycle char_hp=10, alive=1, invuln=0, blink_visible=1.
- Spawn archer; hit_valid held, hit_dmg=2 -> one hit_ack pulse, char_hp=4, invuln=1. Further hit_valid during the window is acked with char_hp unchanged.
- In INVULN, apply 8 frame_ticks -> blink_visible toggles after ticks 2, 4 and 6. After tick 8: invuln=0, blink_visible=1, state ALIVE.
- Archer hp=4, hit_dmg=7 -> char_hp=0, alive=0, death_pulse high for exactly 1 cycle. A subsequent game_start gives char_hp=6, alive=1.
- Melee hp=9, heal_amt=5 -> char_hp=10 (clamped). In a cycle with hit_dmg=3 plus heal_amt=3 -> char_hp=7.
- Mid-INVULN, set game_active=0 -> next cycle char_hp=0, alive=0, invuln=0, state IDLE. Also assert rst while in INVULN -> outputs return to reset values immediately.
